// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;

    // Width of an iteration counter that must hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_adderche.sv
// Plain ripple-style W-bit adder with carry-in (the shared ALU adder block).
// Callers size W one bit wider than their operands so the carry lands in sum.
module adderche #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multicycle unsigned shift-and-add multiplier controller.
// One iteration per clock through a single shared WIDTH+1-bit adder; the
// running product lives in {acc_hi, mplr} and shifts right each iteration.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_w(WIDTH);

    mul_state_t       state;
    mul_state_t       state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   sum;
    logic             last_iter;

    // Operand gate stays here: add the multiplicand only when the current
    // multiplier LSB is set. The extra top bit keeps the carry.
    assign add_a     = {1'b0, acc_hi};
    assign add_b     = mplr[0] ? {1'b0, mcand} : '0;
    assign last_iter = (count == CW'(1));

    adderche #(
        .W (WIDTH + 1)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b0),
        .sum (sum)
    );

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last iteration, DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            mplr    <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplr   <= b;
                        acc_hi <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    // 2*WIDTH+1-bit right shift of {sum, mplr}: the adder
                    // carry becomes the new MSB, mplr LSB falls off.
                    acc_hi <= sum[WIDTH:1];
                    mplr   <= {sum[0], mplr[WIDTH-1:1]};
                    count  <= count - CW'(1);
                    if (last_iter) begin
                        product <= {sum, mplr[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
